// File: rtl/arc4_pkg.sv
// ARC4 shared package.
// Holds the state encodings and constants used by the ARC4 blocks: the
// key-scheduling FSM types and the PRGA (keystream/decrypt) FSM types.
`timescale 1ns/1ps
package arc4_pkg;

  // Address of the length byte in the ciphertext RAM.
  localparam logic [7:0] LEN_ADDR = 8'd0;

  // Cycles spent by the PRGA per message byte (RD_SI .. WR_PT).
  localparam int CYCLES_PER_BYTE = 9;

  // Key-scheduling FSM states.
  typedef enum logic [2:0] {
    KSA_IDLE,
    KSA_INIT,
    KSA_RD_SI,
    KSA_WT_SI,
    KSA_RD_SJ,
    KSA_WT_SJ,
    KSA_WR_SI,
    KSA_WR_SJ
  } ksa_state_t;

  // PRGA FSM states. RD_* present an address, WT_* capture the
  // synchronous RAM read data, WR_* issue a write.
  typedef enum logic [3:0] {
    IDLE,
    RD_LEN,
    WT_LEN,
    WR_LEN,
    RD_SI,
    WT_SI,
    RD_SJ,
    WT_SJ,
    WR_SI,
    WR_SJ,
    RD_PAD,
    WT_PAD,
    WR_PT
  } prga_state_t;

endpackage

// File: rtl/prga.sv
// ARC4 pseudo-random generation / decrypt block.
// Reads length L and L ciphertext bytes from the ciphertext RAM, runs the
// RC4 keystream over the S-box RAM left by key scheduling, and writes L
// followed by the L plaintext bytes to the plaintext RAM.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   en / rdy                      start request / idle indication
//   s_addr, s_wrdata, s_wren      S-box RAM port; s_rddata read data
//   ct_addr                       ciphertext RAM address; ct_rddata read data
//   pt_addr, pt_wrdata, pt_wren   plaintext RAM write port
// All RAMs are synchronous: read data is valid the cycle after the address.
`timescale 1ns/1ps
module prga
  import arc4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  input  logic [7:0] s_rddata,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  prga_state_t state, state_nx;

  logic [7:0] i;        // S index, increments per byte
  logic [7:0] j;        // S index, accumulates S[i]
  logic [7:0] k;        // message byte index, 1..L
  logic [7:0] len;      // message length L
  logic [7:0] si;       // S[i] before swap
  logic [7:0] sj;       // S[j] before swap
  logic [7:0] pad;      // keystream byte
  logic [7:0] ct_byte;  // ciphertext byte k

  // Datapath registers and the state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // in this block samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      i       <= 8'd0;
      j       <= 8'd0;
      k       <= 8'd0;
      len     <= 8'd0;
      si      <= 8'd0;
      sj      <= 8'd0;
      pad     <= 8'd0;
      ct_byte <= 8'd0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (en) begin
            i <= 8'd0;
            j <= 8'd0;
            k <= 8'd0;
          end
        end
        WT_LEN: len <= ct_rddata;
        WR_LEN: begin
          if (len != 8'd0) begin
            i <= 8'd1;
            k <= 8'd1;
          end
        end
        WT_SI: begin
          si <= s_rddata;
          j  <= j + s_rddata;  // wraps mod 256
        end
        WT_SJ: sj <= s_rddata;
        WT_PAD: begin
          pad     <= s_rddata;
          ct_byte <= ct_rddata;
        end
        WR_PT: begin
          if (k != len) begin
            k <= k + 8'd1;
            i <= i + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and RAM port drive. Outputs are purely a function of the
  // current state so reset forces them to 0 the moment IDLE is entered.
  // NOTE: every output gets a default before the case so no path through
  // this block leaves a value unassigned (which would infer a latch).
  always_comb begin
    state_nx  = state;
    s_addr    = 8'd0;
    s_wrdata  = 8'd0;
    s_wren    = 1'b0;
    ct_addr   = 8'd0;
    pt_addr   = 8'd0;
    pt_wrdata = 8'd0;
    pt_wren   = 1'b0;
    unique case (state)
      IDLE:   if (en) state_nx = RD_LEN;
      RD_LEN: begin
        ct_addr  = LEN_ADDR;
        state_nx = WT_LEN;
      end
      WT_LEN: state_nx = WR_LEN;
      WR_LEN: begin
        pt_addr   = LEN_ADDR;
        pt_wrdata = len;
        pt_wren   = 1'b1;
        state_nx  = (len == 8'd0) ? IDLE : RD_SI;
      end
      RD_SI: begin
        s_addr   = i;
        state_nx = WT_SI;
      end
      WT_SI: state_nx = RD_SJ;
      RD_SJ: begin
        s_addr   = j;
        state_nx = WT_SJ;
      end
      WT_SJ: state_nx = WR_SI;
      // The swap always issues both writes; when i == j they hit the same
      // address with the same value, which leaves S unchanged.
      WR_SI: begin
        s_addr   = i;
        s_wrdata = sj;
        s_wren   = 1'b1;
        state_nx = WR_SJ;
      end
      WR_SJ: begin
        s_addr   = j;
        s_wrdata = si;
        s_wren   = 1'b1;
        state_nx = RD_PAD;
      end
      // After the swap S[i] = sj and S[j] = si, so the pad index is si+sj.
      RD_PAD: begin
        s_addr   = si + sj;
        ct_addr  = k;
        state_nx = WT_PAD;
      end
      WT_PAD: state_nx = WR_PT;
      WR_PT: begin
        pt_addr   = k;
        pt_wrdata = pad ^ ct_byte;
        pt_wren   = 1'b1;
        state_nx  = (k == len) ? IDLE : RD_SI;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign rdy = (state == IDLE);

endmodule

// File: tb/tb_prga.sv
// Self-checking bench for prga: synchronous RAM models for S, ciphertext and
// plaintext, a table of directed vectors with hand-computed results, an RC4
// reference model for the long-message and reset-recovery sequences, and a
// per-cycle monitor on the RAM port behaviour.
`timescale 1ns/1ps
module tb_prga;
  import arc4_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       rdy;
  logic [7:0] s_addr, s_wrdata, s_rddata;
  logic       s_wren;
  logic [7:0] ct_addr, ct_rddata;
  logic [7:0] pt_addr, pt_wrdata;
  logic       pt_wren;

  logic [7:0] s_mem  [256];
  logic [7:0] ct_mem [256];
  logic [7:0] pt_mem [256];
  logic [7:0] s_snap [256];
  logic [7:0] exp_pt [256];
  logic [7:0] exp_s  [256];

  int n_tests = 0;
  int n_fail  = 0;
  int s_wr_cnt = 0;
  int pt_wr_cnt = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  prga dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren), .s_rddata(s_rddata),
    .ct_addr(ct_addr), .ct_rddata(ct_rddata),
    .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
  );

  // Synchronous RAM models.
  always @(posedge clk) begin
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
    if (s_wren) begin
      s_mem[s_addr] <= s_wrdata;
      s_wr_cnt <= s_wr_cnt + 1;
    end
    if (pt_wren) begin
      pt_mem[pt_addr] <= pt_wrdata;
      pt_wr_cnt <= pt_wr_cnt + 1;
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Per-cycle port behaviour: writes only in write states, and outputs are
  // zero in states that do not drive them.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      prga_state_t st;
      bit ok;
      st = dut.state;
      ok = 1'b1;
      if (s_wren && !(st inside {WR_SI, WR_SJ})) ok = 1'b0;
      if (pt_wren && !(st inside {WR_LEN, WR_PT})) ok = 1'b0;
      if (ct_addr != 8'd0 && st != RD_PAD) ok = 1'b0;
      if (s_addr != 8'd0 && !(st inside {RD_SI, RD_SJ, WR_SI, WR_SJ, RD_PAD})) ok = 1'b0;
      if (s_wrdata != 8'd0 && !(st inside {WR_SI, WR_SJ})) ok = 1'b0;
      if ((pt_addr != 8'd0 || pt_wrdata != 8'd0) && !(st inside {WR_LEN, WR_PT})) ok = 1'b0;
      if (s_wren && st == WR_SI && s_addr != dut.i) ok = 1'b0;
      if (s_wren && st == WR_SJ && s_addr != dut.j) ok = 1'b0;
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL port_rules: state=%s s_addr=%0h s_wren=%0b ct_addr=%0h pt_addr=%0h pt_wren=%0b",
                 st.name(), s_addr, s_wren, ct_addr, pt_addr, pt_wren);
      end
    end
  end

  task automatic load_s(input bit rev);
    for (int x = 0; x < 256; x++) s_mem[x] = rev ? 8'(255 - x) : 8'(x);
  endtask

  task automatic fill_pt();
    for (int x = 0; x < 256; x++) pt_mem[x] = 8'hEE;
  endtask

  // Behavioural RC4 PRGA over the current S snapshot and ciphertext.
  task automatic run_model(input int len);
    logic [7:0] s [256];
    logic [7:0] mi, mj, t;
    for (int x = 0; x < 256; x++) s[x] = s_mem[x];
    mi = 0; mj = 0;
    exp_pt[0] = 8'(len);
    for (int n = 1; n <= len; n++) begin
      mi = mi + 8'd1;
      mj = mj + s[mi];
      t = s[mi]; s[mi] = s[mj]; s[mj] = t;
      t = s[mi] + s[mj];
      exp_pt[n] = ct_mem[n] ^ s[t];
    end
    for (int x = 0; x < 256; x++) exp_s[x] = s[x];
  endtask

  // Start a pass and count cycles from the edge that samples en until rdy
  // is seen high again.
  task automatic start_and_wait(output int lat);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    lat = 1;
    check("rdy_low_after_en", int'(rdy), 0);
    while (!rdy && lat < 3000) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (!rdy) check("done_timeout", 0, 1);
  endtask

  typedef struct {
    bit         rev;
    int         len;
    logic [7:0] ct1, ct2;
    logic [7:0] pt1, pt2;
    int         lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int lat, s0, p0, w;
    bit hit;

    // Hand-computed vectors (identity or reversed S).
    vecs[0] = '{0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 4};
    vecs[1] = '{0, 1, 8'h41, 8'h00, 8'h43, 8'h00, 13};
    vecs[2] = '{0, 1, 8'h00, 8'h00, 8'h02, 8'h00, 13};
    vecs[3] = '{0, 2, 8'h00, 8'h00, 8'h02, 8'h05, 22};
    vecs[4] = '{0, 2, 8'h10, 8'h20, 8'h12, 8'h25, 22};
    vecs[5] = '{1, 1, 8'h5A, 8'h00, 8'h5A, 8'h00, 13};

    load_s(0);
    fill_pt();
    for (int x = 0; x < 256; x++) ct_mem[x] = 8'h00;

    // Reset state.
    #2;
    check("reset_rdy", int'(rdy), 1);
    check("reset_outputs", int'({s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset", int'(rdy), 1);

    // Table-driven vectors.
    foreach (vecs[v]) begin
      load_s(vecs[v].rev);
      fill_pt();
      ct_mem[0] = 8'(vecs[v].len);
      ct_mem[1] = vecs[v].ct1;
      ct_mem[2] = vecs[v].ct2;
      s0 = s_wr_cnt; p0 = pt_wr_cnt;
      start_and_wait(lat);
      check($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      check($sformatf("v%0d_pt0", v), int'(pt_mem[0]), vecs[v].len);
      if (vecs[v].len >= 1) check($sformatf("v%0d_pt1", v), int'(pt_mem[1]), int'(vecs[v].pt1));
      if (vecs[v].len >= 2) check($sformatf("v%0d_pt2", v), int'(pt_mem[2]), int'(vecs[v].pt2));
      check($sformatf("v%0d_s_writes", v), s_wr_cnt - s0, 2 * vecs[v].len);
      check($sformatf("v%0d_pt_writes", v), pt_wr_cnt - p0, vecs[v].len + 1);
      if (vecs[v].len == 1 && !vecs[v].rev) check($sformatf("v%0d_s1_kept", v), int'(s_mem[1]), 1);
    end

    // Handshake: en toggling while busy, then held across completion.
    load_s(0);
    fill_pt();
    ct_mem[0] = 8'd1; ct_mem[1] = 8'h41;
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    check("hs_rdy_low", int'(rdy), 0);
    while (!rdy && lat < 100) begin
      en = ~en;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    en = 1'b1;
    check("hs_pass1_latency", lat, 13);
    check("hs_pass1_pt1", int'(pt_mem[1]), 8'h43);
    pt_mem[1] = 8'h00;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    check("hs_pass2_started", int'(rdy), 0);
    lat = 1;
    while (!rdy && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("hs_pass2_latency", lat, 13);
    check("hs_pass2_pt1_ij_cleared", int'(pt_mem[1]), 8'h43);

    // L = 255, all-zero ciphertext: keystream and final S against the model.
    load_s(0);
    fill_pt();
    ct_mem[0] = 8'd255;
    for (int x = 1; x < 256; x++) ct_mem[x] = 8'h00;
    run_model(255);
    start_and_wait(lat);
    check("l255_latency", lat, 4 + CYCLES_PER_BYTE * 255);
    for (int x = 0; x < 256; x++) check($sformatf("l255_pt%0d", x), int'(pt_mem[x]), int'(exp_pt[x]));
    for (int x = 0; x < 256; x++) check($sformatf("l255_s%0d", x), int'(s_mem[x]), int'(exp_s[x]));

    // Reset during WR_SI of byte 3.
    load_s(0);
    fill_pt();
    ct_mem[0] = 8'd5;
    for (int x = 1; x <= 5; x++) ct_mem[x] = 8'(8'h30 + x);
    run_model(5);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (dut.state == WR_SI && dut.k == 8'd3) hit = 1'b1;
      else @(negedge clk);
    end
    check("rst_reached_wr_si_byte3", int'(hit), 1);
    rst_n = 1'b0;
    #1;
    check("rst_rdy_immediate", int'(rdy), 1);
    check("rst_outputs_immediate", int'({s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren}), 0);
    s0 = s_wr_cnt; p0 = pt_wr_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_no_s_writes", s_wr_cnt - s0, 0);
    check("rst_no_pt_writes", pt_wr_cnt - p0, 0);
    check("rst_waits_idle", int'(rdy), 1);
    check("rst_pt1_kept", int'(pt_mem[1]), int'(exp_pt[1]));
    check("rst_pt2_kept", int'(pt_mem[2]), int'(exp_pt[2]));
    check("rst_pt3_untouched", int'(pt_mem[3]), 8'hEE);

    // Clean rerun after the abort.
    load_s(0);
    fill_pt();
    run_model(5);
    start_and_wait(lat);
    check("rerun_latency", lat, 4 + CYCLES_PER_BYTE * 5);
    w = 0;
    for (int x = 0; x <= 5; x++) check($sformatf("rerun_pt%0d", x), int'(pt_mem[x]), int'(exp_pt[x]));
    for (int x = 0; x < 256; x++) if (s_mem[x] !== exp_s[x]) w++;
    check("rerun_s_diffs", w, 0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
